// File: rtl/scr_test_pkg.sv
`default_nettype none
// ============================================================================
// Module : scr_test_pkg
// Desc   : Shared state encoding, fault_code bit map and timer width for the
//          SCR test sequencer.
// Rev    : 1.0
// ============================================================================
package scr_test_pkg;

  localparam int unsigned TMR_W = 21;

  localparam int unsigned FC_FWD_BRK = 3;
  localparam int unsigned FC_NEG_BRK = 2;
  localparam int unsigned FC_FWD_BOD = 1;
  localparam int unsigned FC_NEG_BOD = 0;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SETTLE     = 4'd1,
    ST_FWD_PULSE  = 4'd2,
    ST_FWD_WAIT   = 4'd3,
    ST_FWD_SAMPLE = 4'd4,
    ST_NEG_PULSE  = 4'd5,
    ST_NEG_WAIT   = 4'd6,
    ST_NEG_SAMPLE = 4'd7,
    ST_DONE       = 4'd8
  } seq_state_e;

`ifdef SCR_SEQ_FAULT_ABORT_EN
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/scr_seq_timer.sv
`default_nettype none
// ============================================================================
// Module : scr_seq_timer
// Desc   : Loadable saturating up-counter; tc_hit_o flags count >= tc_i - 1.
// Rev    : 1.0
// ============================================================================
module scr_seq_timer
  import scr_test_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] tc_i,
  output logic             tc_hit_o
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Written as count+1 >= tc so a zero terminal count cannot underflow.
  assign tc_hit_o = ({1'b0, count_q} + 22'd1) >= {1'b0, tc_i};

endmodule
`default_nettype wire

// File: rtl/scr_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module : scr_test_sequencer
// Desc   : Trigger/forbid sequencer and sticky fault accumulator for the SCR
//          breakdown/BOD checker. Option macro: SCR_SEQ_FAULT_ABORT_EN.
// Rev    : 1.0
// ============================================================================
module scr_test_sequencer
  import scr_test_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH  = 500,
  parameter int unsigned CYCLE_TIME   = 1000000,
  parameter int unsigned SETTLE_TIME  = 50000
`ifdef SCR_SEQ_FAULT_ABORT_EN
  ,
  parameter int unsigned FAULT_THRESH = 3
`endif
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_cycles,
  input  logic        i_SCR_forward_state,
  input  logic        i_SCR_negative_state,
  input  logic        i_SCR_forward_BOD,
  input  logic        i_SCR_negative_BOD,
  output logic        o_signal_forward,
  output logic        o_signal_negative,
  output logic        o_signal_forbid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [3:0]  o_fault_code,
  output logic [15:0] o_cycle_cnt
);

  localparam logic [TMR_W-1:0] c_settle_tc = TMR_W'(SETTLE_TIME);
  localparam logic [TMR_W-1:0] c_pulse_tc  = TMR_W'(PULSE_WIDTH);
  // Pulse + wait + one sample clock make pulse starts exactly CYCLE_TIME apart.
  localparam logic [TMR_W-1:0] c_wait_tc   = TMR_W'(CYCLE_TIME - PULSE_WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic [15:0]      cnt_q, cnt_d, cycles_q, cycles_d;
  logic             fwd_q, neg_q, forbid_q, busy_q, done_q, fault_q;
  logic [TMR_W-1:0] w_tc;
  logic             w_tc_hit, w_last_pair;

  assign w_last_pair = ({1'b0, cnt_q} + 17'd1) == {1'b0, cycles_q};

`ifdef SCR_SEQ_FAULT_ABORT_EN
  logic [1:0] ffc_q, ffc_d, nfc_q, nfc_d;
  logic       w_fwd_bad, w_neg_bad, w_fwd_abort, w_neg_abort;

  assign w_fwd_bad   = !i_SCR_negative_state || i_SCR_forward_BOD;
  assign w_neg_bad   = !i_SCR_forward_state  || i_SCR_negative_BOD;
  assign w_fwd_abort = w_fwd_bad && (({30'd0, ffc_q} + 32'd1) >= FAULT_THRESH);
  assign w_neg_abort = w_neg_bad && (({30'd0, nfc_q} + 32'd1) >= FAULT_THRESH);

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      ffc_q <= 2'd0;
      nfc_q <= 2'd0;
    end else begin
      ffc_q <= ffc_d;
      nfc_q <= nfc_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    w_tc     = c_pulse_tc;
`ifdef SCR_SEQ_FAULT_ABORT_EN
    ffc_d    = ffc_q;
    nfc_d    = nfc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          code_d   = '0;
          cnt_d    = '0;
          cycles_d = i_cycles;
`ifdef SCR_SEQ_FAULT_ABORT_EN
          ffc_d    = 2'd0;
          nfc_d    = 2'd0;
`endif
          state_d  = (i_cycles == 16'd0) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_tc = c_settle_tc;
        if (i_stop)        state_d = ST_DONE;
        else if (w_tc_hit) state_d = ST_FWD_PULSE;
      end
      ST_FWD_PULSE: begin
        if (i_stop)        state_d = ST_DONE;
        else if (w_tc_hit) state_d = ST_FWD_WAIT;
      end
      ST_FWD_WAIT: begin
        w_tc = c_wait_tc;
        if (i_stop)        state_d = ST_DONE;
        else if (w_tc_hit) state_d = ST_FWD_SAMPLE;
      end
      ST_FWD_SAMPLE: begin
        if (i_stop) begin
          state_d = ST_DONE;
        end else begin
          code_d[FC_NEG_BRK] = code_q[FC_NEG_BRK] | !i_SCR_negative_state;
          code_d[FC_FWD_BOD] = code_q[FC_FWD_BOD] | i_SCR_forward_BOD;
          state_d            = ST_NEG_PULSE;
`ifdef SCR_SEQ_FAULT_ABORT_EN
          ffc_d = w_fwd_bad ? sat_inc2(ffc_q) : 2'd0;
          if (w_fwd_abort) state_d = ST_DONE;
`endif
        end
      end
      ST_NEG_PULSE: begin
        if (i_stop)        state_d = ST_DONE;
        else if (w_tc_hit) state_d = ST_NEG_WAIT;
      end
      ST_NEG_WAIT: begin
        w_tc = c_wait_tc;
        if (i_stop)        state_d = ST_DONE;
        else if (w_tc_hit) state_d = ST_NEG_SAMPLE;
      end
      ST_NEG_SAMPLE: begin
        if (i_stop) begin
          state_d = ST_DONE;
        end else begin
          code_d[FC_FWD_BRK] = code_q[FC_FWD_BRK] | !i_SCR_forward_state;
          code_d[FC_NEG_BOD] = code_q[FC_NEG_BOD] | i_SCR_negative_BOD;
          cnt_d              = cnt_q + 16'd1;
          state_d            = w_last_pair ? ST_DONE : ST_FWD_PULSE;
`ifdef SCR_SEQ_FAULT_ABORT_EN
          nfc_d = w_neg_bad ? sat_inc2(nfc_q) : 2'd0;
          if (w_neg_abort) state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  scr_seq_timer u_timer (
    .clk_i    (i_clk_50m),
    .rst_i    (i_rst),
    .load_i   (state_d != state_q),
    .tc_i     (w_tc),
    .tc_hit_o (w_tc_hit)
  );

  // Outputs decode the next state so they change on the same edge as the FSM.
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
      cycles_q <= '0;
      fwd_q    <= 1'b0;
      neg_q    <= 1'b0;
      forbid_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      fault_q  <= |code_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      fwd_q    <= (state_d == ST_FWD_PULSE);
      neg_q    <= (state_d == ST_NEG_PULSE);
      forbid_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign o_signal_forward  = fwd_q;
  assign o_signal_negative = neg_q;
  assign o_signal_forbid   = forbid_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_fault           = fault_q;
  assign o_fault_code      = code_q;
  assign o_cycle_cnt       = cnt_q;

endmodule
`default_nettype wire
